// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers up to 63 payload bytes, then sends them to a router
// port as HEADER {len,dest}, the payload bytes, and an XOR parity byte, with
// every presented byte held while the router asserts busy.
// Optional feature: define PARITY_INJECT_EN to add the inject_err input.
// When that input is sampled high with an accepted start, the parity byte is
// sent bitwise inverted.
module router_pkt_tx (
    input  logic       clock,
    input  logic       reset,
    input  logic       pay_wr,
    input  logic [7:0] pay_data,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic       busy,
`ifdef PARITY_INJECT_EN
    input  logic       inject_err,
`endif
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       req_err,
    output logic [5:0] buf_count,
    output logic       buf_full
);

    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 63;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PARITY  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          count_q, count_d;
    logic [5:0]          rd_ptr_q, rd_ptr_d;
    logic [5:0]          len_q, len_d;
    logic [1:0]          dest_q, dest_d;
    logic [DATA_W-1:0]   parity_q, parity_d;
    logic                req_err_q, req_err_d;
`ifdef PARITY_INJECT_EN
    logic                inject_q, inject_d;
`endif

    // Payload storage is never reset; it is unobservable while count is 0.
    logic [DATA_W-1:0]   buf_mem_q [0:BUF_DEPTH-1];
    logic                wr_en;
    logic [DATA_W-1:0]   rd_byte;
    logic [DATA_W-1:0]   header_byte;
    logic [DATA_W-1:0]   parity_byte;

    assign header_byte = {len_q, dest_q};
    assign rd_byte     = buf_mem_q[rd_ptr_q];

`ifdef PARITY_INJECT_EN
    assign parity_byte = inject_q ? ~parity_q : parity_q;
`else
    assign parity_byte = parity_q;
`endif

    // Payload buffer write port; writes land at the current fill level.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_mem_q[count_q] <= pay_data;
        end
    end

    // Control and packet state registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= 6'd0;
            rd_ptr_q  <= 6'd0;
            len_q     <= 6'd0;
            dest_q    <= 2'd0;
            parity_q  <= '0;
            req_err_q <= 1'b0;
`ifdef PARITY_INJECT_EN
            inject_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            len_q     <= len_d;
            dest_q    <= dest_d;
            parity_q  <= parity_d;
            req_err_q <= req_err_d;
`ifdef PARITY_INJECT_EN
            inject_q  <= inject_d;
`endif
        end
    end

    // Next-state logic: buffer fill, start qualification, and per-accept
    // advance through header, payload and parity (busy freezes everything).
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        len_d     = len_q;
        dest_d    = dest_q;
        parity_d  = parity_q;
        req_err_d = 1'b0;
        wr_en     = 1'b0;
`ifdef PARITY_INJECT_EN
        inject_d  = inject_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A start cycle never also writes, so a rejected start
                    // leaves the buffer exactly as it was.
                    if ((count_q != 6'd0) && (dest_addr != 2'd3)) begin
                        state_d  = S_HEADER;
                        len_d    = count_q;
                        dest_d   = dest_addr;
                        parity_d = '0;
                        rd_ptr_d = 6'd0;
`ifdef PARITY_INJECT_EN
                        inject_d = inject_err;
`endif
                    end else begin
                        req_err_d = 1'b1;
                    end
                end else if (pay_wr && !buf_full) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 6'd1;
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    parity_d = parity_q ^ header_byte;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ rd_byte;
                    if (rd_ptr_q == (len_q - 6'd1)) begin
                        state_d = S_PARITY;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 6'd1;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                count_d  = 6'd0;
                rd_ptr_d = 6'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode straight from state, so a held state holds the byte.
    always_comb begin
        pkt_valid = 1'b0;
        data_out  = '0;
        case (state_q)
            S_HEADER: begin
                pkt_valid = 1'b1;
                data_out  = header_byte;
            end
            S_PAYLOAD: begin
                pkt_valid = 1'b1;
                data_out  = rd_byte;
            end
            S_PARITY: begin
                pkt_valid = 1'b0;
                data_out  = parity_byte;
            end
            default: begin
                pkt_valid = 1'b0;
                data_out  = '0;
            end
        endcase
    end

    assign tx_active = (state_q == S_HEADER) || (state_q == S_PAYLOAD) ||
                       (state_q == S_PARITY);
    assign tx_done   = (state_q == S_DONE);
    assign req_err   = req_err_q;
    assign buf_count = count_q;
    assign buf_full  = (count_q == 6'(BUF_DEPTH));

endmodule
